// File: rtl/bus_fabric.sv
// rtl/bus_fabric.sv - one-hot source bus with keeper, contention fault FSM and transfer/contention counters
// Defining BUS_FABRIC_TRACE_EN adds o_lastSrc/o_lastSrcValid tracking of the most recent single driver.
module bus_fabric #(
  parameter int DATA_WIDTH = 8,
  parameter int N_SRC      = 5,
  parameter int N_DST      = 6,
  parameter int CNT_WIDTH  = 16,
  localparam int SRC_IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [N_SRC*DATA_WIDTH-1:0] i_srcData,
  input  logic [N_SRC-1:0]            i_srcOe,
  input  logic [N_DST-1:0]            i_dstWr,
  input  logic                        i_faultClr,
  output logic [DATA_WIDTH-1:0]       o_bus,
  output logic [DATA_WIDTH-1:0]       o_busQ,
  output logic [N_DST-1:0]            o_dstWr,
  output logic                        o_contention,
  output logic                        o_fault,
  output logic [N_SRC-1:0]            o_faultSrc,
  output logic [CNT_WIDTH-1:0]        o_xferCnt,
`ifdef BUS_FABRIC_TRACE_EN
  output logic [SRC_IDX_W-1:0]        o_lastSrc,
  output logic                        o_lastSrcValid,
`endif
  output logic [CNT_WIDTH-1:0]        o_contCnt
);

  typedef enum logic {ST_OK, ST_FAULT} state_t;

  logic [DATA_WIDTH-1:0] sel_data;
  logic                  any_oe;
  logic                  multi_oe;
  logic                  single_oe;

  logic [DATA_WIDTH-1:0] keeper_d, keeper_q;
  logic [DATA_WIDTH-1:0] bus_q_d, bus_q_q;
  logic [CNT_WIDTH-1:0]  xfer_cnt_d, xfer_cnt_q;
  logic [CNT_WIDTH-1:0]  cont_cnt_d, cont_cnt_q;

  state_t                state_q;
  logic                  fault_q;
  logic [N_SRC-1:0]      fault_src_q;

  // Scan downward so the lowest enabled index wins under contention.
  always_comb begin
    sel_data = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (i_srcOe[k]) begin
        sel_data = i_srcData[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign any_oe    = |i_srcOe;
  assign multi_oe  = |(i_srcOe & (i_srcOe - N_SRC'(1)));
  assign single_oe = any_oe & ~multi_oe;

  assign o_bus        = any_oe ? sel_data : keeper_q;
  assign o_contention = multi_oe;
  assign o_dstWr      = multi_oe ? '0 : i_dstWr;

  always_comb begin
    keeper_d   = single_oe ? o_bus : keeper_q;
    bus_q_d    = o_bus;
    xfer_cnt_d = xfer_cnt_q;
    if (single_oe && (|i_dstWr)) begin
      xfer_cnt_d = xfer_cnt_q + CNT_WIDTH'(1);
    end
    cont_cnt_d = cont_cnt_q;
    if (multi_oe && (cont_cnt_q != {CNT_WIDTH{1'b1}})) begin
      cont_cnt_d = cont_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      keeper_q   <= '0;
      bus_q_q    <= '0;
      xfer_cnt_q <= '0;
      cont_cnt_q <= '0;
    end else begin
      keeper_q   <= keeper_d;
      bus_q_q    <= bus_q_d;
      xfer_cnt_q <= xfer_cnt_d;
      cont_cnt_q <= cont_cnt_d;
    end
  end

  // Re-contention takes priority over a clear request while faulted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_OK;
      fault_q     <= 1'b0;
      fault_src_q <= '0;
    end else begin
      case (state_q)
        ST_OK: begin
          if (multi_oe) begin
            state_q     <= ST_FAULT;
            fault_q     <= 1'b1;
            fault_src_q <= i_srcOe;
          end
        end
        ST_FAULT: begin
          if (multi_oe) begin
            fault_src_q <= i_srcOe;
          end else if (i_faultClr) begin
            state_q <= ST_OK;
            fault_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_OK;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_busQ     = bus_q_q;
  assign o_fault    = fault_q;
  assign o_faultSrc = fault_src_q;
  assign o_xferCnt  = xfer_cnt_q;
  assign o_contCnt  = cont_cnt_q;

`ifdef BUS_FABRIC_TRACE_EN
  logic [SRC_IDX_W-1:0] sel_idx;
  logic [SRC_IDX_W-1:0] last_src_d, last_src_q;
  logic                 last_valid_d, last_valid_q;

  always_comb begin
    sel_idx = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (i_srcOe[k]) begin
        sel_idx = SRC_IDX_W'(k);
      end
    end
    last_src_d   = single_oe ? sel_idx : last_src_q;
    last_valid_d = last_valid_q | single_oe;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      last_src_q   <= '0;
      last_valid_q <= 1'b0;
    end else begin
      last_src_q   <= last_src_d;
      last_valid_q <= last_valid_d;
    end
  end

  assign o_lastSrc      = last_src_q;
  assign o_lastSrcValid = last_valid_q;
`endif

endmodule

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
- Parametrised successor to the single shared 8-bit datapath bus: resolves N_SRC one-hot source enables onto one DATA_WIDTH bus and fans the value out to N_DST write-strobed destinations.
- Adds features the plain bus lacks: a bus keeper, contention detection with a fault state machine, destination-write suppression on contention, and transfer/contention counters.
- Sits between the control unit and all datapath units (ALU, regset, RAM, PC, immediate).

Parameters:
DATA_WIDTH, 8, bus width in bits
N_SRC, 5, number of bus sources (ALU, regs, RAM, PC, immediate)
N_DST, 6, number of destination write strobes
CNT_WIDTH, 16, width of transfer and contention counters

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_reset  input  1  synchronous reset, active-high
i_srcData  input  N_SRC*DATA_WIDTH  flattened source data; source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
i_srcOe  input  N_SRC  per-source output enable
i_dstWr  input  N_DST  requested destination write strobes from control
i_faultClr  input  1  clears sticky fault
o_bus  output  DATA_WIDTH  resolved bus value (combinational)
o_busQ  output  DATA_WIDTH  o_bus registered one cycle
o_dstWr  output  N_DST  qualified destination strobes (combinational)
o_contention  output  1  more than one i_srcOe bit set this cycle (combinational)
o_fault  output  1  sticky fault flag
o_faultSrc  output  N_SRC  i_srcOe captured at the most recent contention
o_xferCnt  output  CNT_WIDTH  count of completed transfers
o_contCnt  output  CNT_WIDTH  count of contention cycles

Behaviour:
- Resolution, by popcount of i_srcOe:
  - Exactly one bit set: o_bus = that source's data.
  - Zero bits set: o_bus = keeper register (last value driven by a single source).
  - Two or more bits set: o_bus = lowest-index enabled source; o_contention = 1.
- Keeper: loads o_bus each cycle with exactly one driver; holds otherwise. Reset value 0.
- o_busQ: o_bus delayed one cycle. Reset value 0.
- o_dstWr: equals i_dstWr when o_contention = 0; forced to all-zero when o_contention = 1. With zero drivers, strobes pass and destinations receive the keeper value.
- Fault FSM, states ST_OK and ST_FAULT:
  - ST_OK -> ST_FAULT when o_contention = 1; o_faultSrc <= i_srcOe.
  - ST_FAULT -> ST_OK when i_faultClr = 1 and o_contention = 0.
  - In ST_FAULT with o_contention = 1 (including simultaneous i_faultClr): stay in ST_FAULT; o_faultSrc recaptures the new i_srcOe.
  - o_fault = 1 exactly when the state is ST_FAULT (registered). The fault does not block bus operation.
- o_xferCnt: increments when exactly one source is enabled and |i_dstWr = 1. Wraps modulo 2^CNT_WIDTH.
- o_contCnt: increments on every o_contention cycle. Saturates at 2^CNT_WIDTH-1.
- Reset (any cycle, including mid-fault): state ST_OK, keeper/o_busQ/o_faultSrc/counters = 0. Combinational outputs follow inputs during reset, except that o_bus uses keeper = 0 once reset has been sampled.

Optional Feature:
- Macro: BUS_FABRIC_TRACE_EN.
- Defined:
  - Adds output o_lastSrc, width $clog2(N_SRC) (minimum 1).
  - Holds the index of the most recent single driver; updated alongside the keeper; reset 0.
  - Adds output o_lastSrcValid: 0 after reset, set to 1 on the first single-driver cycle.
- Undefined: neither port exists and no trace logic is built. All other behaviour is identical.

Test Plan:
- Single driver: reset, then i_srcOe=5'b00100, source 2 data=8'hA5, i_dstWr=6'b000010 -> o_bus=8'hA5, o_dstWr=6'b000010; next cycle o_busQ=8'hA5, o_xferCnt=1.
- Keeper: after the previous step, i_srcOe=0, i_dstWr=6'b000001 -> o_bus=8'hA5, o_dstWr=6'b000001, o_xferCnt stays 1.
- Contention: i_srcOe=5'b01010, src1=8'h11, src3=8'h33, i_dstWr=6'b111111 -> o_bus=8'h11, o_contention=1, o_dstWr=0; next cycle o_fault=1, o_faultSrc=5'b01010, o_contCnt=1.
- Clear vs re-contention: in fault, i_faultClr=1 with i_srcOe=5'b10001 -> o_fault stays 1, o_faultSrc=5'b10001; then i_faultClr=1 with i_srcOe=5'b00001 -> o_fault=0 next cycle.
- Counter boundaries: CNT_WIDTH=4, 16 single-driver transfers -> o_xferCnt wraps to 0; 20 contention cycles -> o_contCnt=15.
- Reset mid-fault: with o_fault=1, o_contCnt=3 and keeper=8'h5A, assert i_reset for one cycle -> o_fault=0, counters=0, o_faultSrc=0, o_busQ=0, and with i_srcOe=0 o_bus=8'h00.
